// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch-side branch redirect controller.
package riscv_pkg;

   typedef enum logic [0:0] {
      RUN       = 1'b0,
      TRAP_WAIT = 1'b1
   } brs_state_e;

   localparam int unsigned INSN_BYTES      = 4;
   localparam logic [63:0] DEF_RESET_PC    = 64'h0;
   localparam logic [63:0] DEF_TRAP_VECTOR = 64'h100;

   // No compressed instructions, so any nonzero low bits make a bad target.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Fetch/redirect bundle between the branch redirect unit and the pipeline.
interface branch_redirect_unit_if;

   logic        stall;
   logic        branch_ex;
   logic        addermuxselect;
   logic [63:0] branch_target;
   logic        trap_ack;
   logic [63:0] pc_out;
   logic        fetch_en;
   logic        flush_ifid;
   logic        flush_idex;
   logic        trap_req;
   logic [63:0] trap_cause_pc;

   modport master (
      input  stall, branch_ex, addermuxselect, branch_target, trap_ack,
      output pc_out, fetch_en, flush_ifid, flush_idex, trap_req, trap_cause_pc
   );

   modport slave (
      output stall, branch_ex, addermuxselect, branch_target, trap_ack,
      input  pc_out, fetch_en, flush_ifid, flush_idex, trap_req, trap_cause_pc
   );

endinterface

// File: rtl/branch_stats_counter.sv
// Saturating 32-bit event counter used for branch statistics.
module branch_stats_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   output logic [31:0] count
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: branch redirects, wrong-path flushes and misaligned-target trap.
// Optional BRANCH_STATS_EN adds saturating branch/taken counters.
//
// state     | meaning
// RUN       | fetching; PC advances, holds on stall, or redirects on taken branch
// TRAP_WAIT | misaligned target trapped; fetch off, PC parked at TRAP_VECTOR
module branch_redirect_unit
   import riscv_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = DEF_RESET_PC,
   parameter logic [63:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
   input  logic                    clk,
   input  logic                    reset,
   branch_redirect_unit_if.master  bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]             branch_count,
   output logic [31:0]             taken_count
`endif
);

   brs_state_e  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] cause_q, cause_d;
   logic        taken;
   logic        flush;
   logic        fetch_en;
   logic        trap_req;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cause_d  = cause_q;
      taken    = 1'b0;
      flush    = 1'b0;
      fetch_en = 1'b0;
      trap_req = 1'b0;
      case (state_q)
         RUN: begin
            // addermuxselect is stale outside branches, so always qualify it.
            taken    = bus.branch_ex & bus.addermuxselect;
            fetch_en = 1'b1;
            flush    = taken;
            if (taken && is_misaligned(bus.branch_target[1:0])) begin
               pc_d    = TRAP_VECTOR;
               cause_d = bus.branch_target;
               state_d = TRAP_WAIT;
            end else if (taken) begin
               pc_d = bus.branch_target;
            end else if (!bus.stall) begin
               pc_d = pc_q + 64'(INSN_BYTES);
            end
         end
         TRAP_WAIT: begin
            trap_req = 1'b1;
            flush    = 1'b1;
            pc_d     = TRAP_VECTOR;
            if (bus.trap_ack) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         cause_q <= 64'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
      end
   end

   assign bus.pc_out        = pc_q;
   assign bus.fetch_en      = fetch_en;
   assign bus.flush_ifid    = flush;
   assign bus.flush_idex    = flush;
   assign bus.trap_req      = trap_req;
   assign bus.trap_cause_pc = cause_q;

`ifdef BRANCH_STATS_EN
   logic branch_inc;

   assign branch_inc = (state_q == RUN) & bus.branch_ex;

   branch_stats_counter u_branch_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (branch_inc),
      .count (branch_count)
   );

   branch_stats_counter u_taken_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (taken),
      .count (taken_count)
   );
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: vector table plus trap/wrap/reset sequences.
module tb_branch_redirect_unit;
   import riscv_pkg::*;

   typedef struct {
      logic        stall;
      logic        br;
      logic        ams;
      logic        ack;
      logic [63:0] tgt;
      logic [63:0] pc;
      logic        flush;
      logic        req;
      logic        fe;
      logic [63:0] cause;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   vec_t sb[$];
   vec_t vecs[25];

   branch_redirect_unit_if bus ();

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_count;
   logic [31:0] taken_count;
`endif

   branch_redirect_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef BRANCH_STATS_EN
      ,
      .branch_count (branch_count),
      .taken_count  (taken_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic stall, input logic br, input logic ams,
                               input logic ack, input logic [63:0] tgt,
                               input logic [63:0] pc, input logic flush,
                               input logic req, input logic fe,
                               input logic [63:0] cause);
      vec_t v;
      v.stall = stall; v.br = br; v.ams = ams; v.ack = ack; v.tgt = tgt;
      v.pc = pc; v.flush = flush; v.req = req; v.fe = fe; v.cause = cause;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, check it before the next edge.
   task automatic run_vec(input vec_t v, input string name);
      vec_t e;
      bus.stall          = v.stall;
      bus.branch_ex      = v.br;
      bus.addermuxselect = v.ams;
      bus.trap_ack       = v.ack;
      bus.branch_target  = v.tgt;
      sb.push_back(v);
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         cmp({name, ".pc_out"}, bus.pc_out, e.pc);
         cmp({name, ".flush_ifid"}, 64'(bus.flush_ifid), 64'(e.flush));
         cmp({name, ".flush_idex"}, 64'(bus.flush_idex), 64'(e.flush));
         cmp({name, ".trap_req"}, 64'(bus.trap_req), 64'(e.req));
         cmp({name, ".fetch_en"}, 64'(bus.fetch_en), 64'(e.fe));
         if (e.req) cmp({name, ".trap_cause_pc"}, bus.trap_cause_pc, e.cause);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      //               stl br ams ack tgt        pc      fl req fe cause
      vecs[0]  = mk(0, 0, 0, 0, 64'h0,   64'h0,   0, 0, 1, 64'h0);
      vecs[1]  = mk(0, 0, 0, 0, 64'h0,   64'h4,   0, 0, 1, 64'h0);
      vecs[2]  = mk(0, 0, 0, 0, 64'h0,   64'h8,   0, 0, 1, 64'h0);
      vecs[3]  = mk(0, 0, 0, 0, 64'h0,   64'hC,   0, 0, 1, 64'h0);
      vecs[4]  = mk(0, 0, 0, 0, 64'h0,   64'h10,  0, 0, 1, 64'h0);
      vecs[5]  = mk(0, 0, 0, 0, 64'h0,   64'h14,  0, 0, 1, 64'h0);
      vecs[6]  = mk(0, 0, 0, 0, 64'h0,   64'h18,  0, 0, 1, 64'h0);
      vecs[7]  = mk(0, 0, 0, 0, 64'h0,   64'h1C,  0, 0, 1, 64'h0);
      vecs[8]  = mk(1, 0, 0, 0, 64'h0,   64'h20,  0, 0, 1, 64'h0);
      vecs[9]  = mk(1, 0, 0, 0, 64'h0,   64'h20,  0, 0, 1, 64'h0);
      vecs[10] = mk(1, 0, 0, 0, 64'h0,   64'h20,  0, 0, 1, 64'h0);
      vecs[11] = mk(0, 0, 0, 0, 64'h0,   64'h20,  0, 0, 1, 64'h0);
      vecs[12] = mk(1, 1, 1, 0, 64'h80,  64'h24,  1, 0, 1, 64'h0);
      vecs[13] = mk(0, 0, 1, 0, 64'h40,  64'h80,  0, 0, 1, 64'h0);
      vecs[14] = mk(0, 1, 0, 0, 64'h40,  64'h84,  0, 0, 1, 64'h0);
      vecs[15] = mk(0, 0, 0, 0, 64'h0,   64'h88,  0, 0, 1, 64'h0);
      vecs[16] = mk(0, 0, 0, 1, 64'h0,   64'h8C,  0, 0, 1, 64'h0);
      vecs[17] = mk(0, 1, 1, 0, 64'h82,  64'h90,  1, 0, 1, 64'h0);
      vecs[18] = mk(1, 1, 1, 0, 64'h40,  64'h100, 1, 1, 0, 64'h82);
      vecs[19] = mk(0, 0, 0, 0, 64'h0,   64'h100, 1, 1, 0, 64'h82);
      vecs[20] = mk(0, 0, 0, 0, 64'h0,   64'h100, 1, 1, 0, 64'h82);
      vecs[21] = mk(0, 0, 0, 0, 64'h0,   64'h100, 1, 1, 0, 64'h82);
      vecs[22] = mk(0, 0, 0, 1, 64'h0,   64'h100, 1, 1, 0, 64'h82);
      vecs[23] = mk(0, 0, 0, 0, 64'h0,   64'h100, 0, 0, 1, 64'h0);
      vecs[24] = mk(0, 0, 0, 0, 64'h0,   64'h104, 0, 0, 1, 64'h0);

      reset              = 1'b0;
      bus.stall          = 1'b0;
      bus.branch_ex      = 1'b0;
      bus.addermuxselect = 1'b0;
      bus.trap_ack       = 1'b0;
      bus.branch_target  = 64'h0;
      #1;
      cmp("reset.pc_out", bus.pc_out, DEF_RESET_PC);
      cmp("reset.trap_req", 64'(bus.trap_req), 64'd0);
      cmp("reset.trap_cause_pc", bus.trap_cause_pc, 64'd0);
      cmp("reset.flush_ifid", 64'(bus.flush_ifid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 25; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // PC wraps modulo 2^64 with no side effects.
      run_vec(mk(0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h108, 1, 0, 1, 64'h0), "wrap0");
      run_vec(mk(0, 0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 64'h0), "wrap1");
      run_vec(mk(0, 0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 64'h0), "wrap2");
      run_vec(mk(0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 1, 64'h0), "wrap3");

      // Enter TRAP_WAIT with a low-bit-01 target, then reset asynchronously mid-cycle.
      run_vec(mk(0, 1, 1, 0, 64'h201, 64'h4, 1, 0, 1, 64'h0), "mis0");
      bus.branch_ex      = 1'b0;
      bus.addermuxselect = 1'b0;
      bus.branch_target  = 64'h0;
      @(negedge clk);
      cmp("mis1.trap_req", 64'(bus.trap_req), 64'd1);
      cmp("mis1.trap_cause_pc", bus.trap_cause_pc, 64'h201);
      cmp("mis1.pc_out", bus.pc_out, 64'h100);
      #2;
      reset = 1'b0;
      #1;
      cmp("async_rst.pc_out", bus.pc_out, DEF_RESET_PC);
      cmp("async_rst.trap_req", 64'(bus.trap_req), 64'd0);
      cmp("async_rst.trap_cause_pc", bus.trap_cause_pc, 64'd0);
      cmp("async_rst.fetch_en", 64'(bus.fetch_en), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      run_vec(mk(0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 1, 64'h0), "post_rst0");
      run_vec(mk(0, 0, 0, 0, 64'h0, 64'h4, 0, 0, 1, 64'h0), "post_rst1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
